// File: rtl/modmul_arbiter.sv
// rtl/modmul_arbiter.sv - round-robin arbiter sharing one ModMul unit among NREQ requesters
// Grants one requester at a time, runs the ModMul with a timeout, and returns the result to the owner.
module modmul_arbiter #(
    parameter int WIDTH   = 128,
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic [NREQ-1:0]       ack,
    output logic [NREQ-1:0]       rsp_valid,
    output logic                  rsp_err,
    output logic [WIDTH-1:0]      rsp_r,
    output logic                  busy,
    output logic [WIDTH-1:0]      mm_a,
    output logic [WIDTH-1:0]      mm_b,
    output logic                  mm_enable,
    input  logic [WIDTH-1:0]      mm_r,
    input  logic                  mm_done
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_RESP} state_t;

    state_t            r_state;
    logic [IW-1:0]     r_owner;
    logic [CW-1:0]     r_cnt;
    logic [NREQ-1:0]   r_ack;
    logic [NREQ-1:0]   r_rsp_valid;
    logic              r_rsp_err;
    logic [WIDTH-1:0]  r_rsp_r;
    logic              r_busy;
    logic [WIDTH-1:0]  r_mm_a;
    logic [WIDTH-1:0]  r_mm_b;
    logic              r_mm_en;

    logic              w_found;
    logic [IW-1:0]     w_grant;
    int                w_idx;
    logic [WIDTH-1:0]  w_sel_a;
    logic [WIDTH-1:0]  w_sel_b;

    // r_owner doubles as the last owner, so the search starts one past it
    always_comb begin
        w_found = 1'b0;
        w_grant = r_owner;
        w_idx   = 0;
        for (int k = 1; k <= NREQ; k++) begin
            w_idx = (int'(r_owner) + k) % NREQ;
            if (!w_found && req[w_idx[IW-1:0]]) begin
                w_found = 1'b1;
                w_grant = w_idx[IW-1:0];
            end
        end
    end

    assign w_sel_a = req_a[int'(w_grant)*WIDTH +: WIDTH];
    assign w_sel_b = req_b[int'(w_grant)*WIDTH +: WIDTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_owner     <= IW'(NREQ - 1);
            r_cnt       <= '0;
            r_ack       <= '0;
            r_rsp_valid <= '0;
            r_rsp_err   <= 1'b0;
            r_rsp_r     <= '0;
            r_busy      <= 1'b0;
            r_mm_a      <= '0;
            r_mm_b      <= '0;
            r_mm_en     <= 1'b0;
        end else begin
            r_ack       <= '0;
            r_rsp_valid <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_owner <= w_grant;
                        r_mm_a  <= w_sel_a;
                        r_mm_b  <= w_sel_b;
                        r_ack   <= NREQ'(1) << w_grant;
                        r_cnt   <= '0;
                        r_mm_en <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    // completion takes precedence over an expiring timeout on the same edge
                    if (mm_done) begin
                        r_rsp_r     <= mm_r;
                        r_rsp_valid <= NREQ'(1) << r_owner;
                        r_rsp_err   <= 1'b0;
                        r_mm_en     <= 1'b0;
                        r_state     <= S_RESP;
                    end else if (r_cnt == CW'(TIMEOUT - 1)) begin
                        r_rsp_r     <= '0;
                        r_rsp_valid <= NREQ'(1) << r_owner;
                        r_rsp_err   <= 1'b1;
                        r_mm_en     <= 1'b0;
                        r_state     <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_RESP: begin
                    r_rsp_err <= 1'b0;
                    r_busy    <= 1'b0;
                    r_state   <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ack       = r_ack;
    assign rsp_valid = r_rsp_valid;
    assign rsp_err   = r_rsp_err;
    assign rsp_r     = r_rsp_r;
    assign busy      = r_busy;
    assign mm_a      = r_mm_a;
    assign mm_b      = r_mm_b;
    assign mm_enable = r_mm_en;

endmodule

// File: tb/tb_modmul_arbiter.sv
// tb/tb_modmul_arbiter.sv - self-checking bench for modmul_arbiter with a mod-37 ModMul stub
module tb_modmul_arbiter;

    localparam int W  = 128;
    localparam int N  = 4;
    localparam int TO = 16;
    localparam int P  = 37;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic [N-1:0]   ack;
    logic [N-1:0]   rsp_valid;
    logic           rsp_err;
    logic [W-1:0]   rsp_r;
    logic           busy;
    logic [W-1:0]   mm_a;
    logic [W-1:0]   mm_b;
    logic           mm_enable;
    logic [W-1:0]   mm_r = '0;
    logic           mm_done = 1'b0;

    modmul_arbiter #(.WIDTH(W), .NREQ(N), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .req(req), .req_a(req_a), .req_b(req_b),
        .ack(ack), .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_r(rsp_r),
        .busy(busy), .mm_a(mm_a), .mm_b(mm_b), .mm_enable(mm_enable),
        .mm_r(mm_r), .mm_done(mm_done)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [W-1:0] mod_model(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] p;
        p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        return W'(p % P);
    endfunction

    // ModMul stub: mm_done pulses after lat enabled cycles; lat == 0 never completes
    int lat = 1;
    int sc  = 0;
    always @(posedge clk) begin
        if (reset || !mm_enable) begin
            sc      <= 0;
            mm_done <= 1'b0;
        end else begin
            sc      <= sc + 1;
            mm_done <= (lat != 0) && (sc + 1 == lat);
            mm_r    <= mod_model(mm_a, mm_b);
        end
    end

    typedef struct { int idx; logic [W-1:0] r; logic err; } exp_t;
    exp_t rsp_q[$];
    int   ack_q[$];

    // scoreboard and protocol monitor
    logic [W-1:0] prev_a, prev_b;
    logic         prev_en = 1'b0;
    int           gap = 100;
    always @(negedge clk) begin
        if (reset) begin
            gap     = 100;
            prev_en = 1'b0;
        end else begin
            check("ack_onehot0", 256'($onehot0(ack)), 256'(1));
            check("rsp_onehot0", 256'($onehot0(rsp_valid)), 256'(1));
            if (ack != '0) begin
                if (ack_q.size() == 0) check("ack_unexpected", 256'(ack), 256'(0));
                else check("ack_owner", 256'(ack), 256'(N'(1) << ack_q.pop_front()));
            end
            if (rsp_valid != '0) begin
                if (rsp_q.size() == 0) check("rsp_unexpected", 256'(rsp_valid), 256'(0));
                else begin
                    exp_t e;
                    e = rsp_q.pop_front();
                    check("rsp_owner", 256'(rsp_valid), 256'(N'(1) << e.idx));
                    check("rsp_r", 256'(rsp_r), 256'(e.r));
                    check("rsp_err", 256'(rsp_err), 256'(e.err));
                end
            end
            if (mm_enable && prev_en) begin
                check("mm_a_stable", 256'(mm_a), 256'(prev_a));
                check("mm_b_stable", 256'(mm_b), 256'(prev_b));
            end
            if (mm_enable && !prev_en) check("en_gap_ge2", 256'(gap >= 2), 256'(1));
            gap     = mm_enable ? 0 : gap + 1;
            prev_en = mm_enable;
            prev_a  = mm_a;
            prev_b  = mm_b;
        end
    end

    typedef struct {
        int idx; logic [W-1:0] a; logic [W-1:0] b; int lat;
        logic [W-1:0] r; logic err; int cyc;
    } vec_t;
    vec_t vt[8];

    task automatic check_all_zero(input string tag);
        check({tag, "_ack"}, 256'(ack), 256'(0));
        check({tag, "_rsp_valid"}, 256'(rsp_valid), 256'(0));
        check({tag, "_rsp_err"}, 256'(rsp_err), 256'(0));
        check({tag, "_busy"}, 256'(busy), 256'(0));
        check({tag, "_mm_enable"}, 256'(mm_enable), 256'(0));
        check({tag, "_mm_a"}, 256'(mm_a), 256'(0));
        check({tag, "_mm_b"}, 256'(mm_b), 256'(0));
        check({tag, "_rsp_r"}, 256'(rsp_r), 256'(0));
    endtask

    initial begin
        int t;
        int nrsp;
        logic [W-1:0] ca [N];
        logic [W-1:0] cb [N];

        vt[0] = '{2, 123, 456, 1, 33, 1'b0, 2};
        vt[1] = '{0, 5, 7, 2, 35, 1'b0, 3};
        vt[2] = '{3, 100, 200, 5, 20, 1'b0, 6};
        vt[3] = '{1, 36, 36, 1, 1, 1'b0, 2};
        vt[4] = '{2, 0, 999, 3, 0, 1'b0, 4};
        vt[5] = '{1, 11, 3, 0, 0, 1'b1, 16};
        vt[6] = '{3, 10, 10, 15, 26, 1'b0, 16};
        vt[7] = '{0, 10, 10, 14, 26, 1'b0, 15};

        reset = 1'b1;
        req   = '0;
        req_a = '0;
        req_b = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            lat = vt[i].lat;
            req_a[vt[i].idx*W +: W] = vt[i].a;
            req_b[vt[i].idx*W +: W] = vt[i].b;
            req[vt[i].idx] = 1'b1;
            ack_q.push_back(vt[i].idx);
            rsp_q.push_back('{vt[i].idx, vt[i].r, vt[i].err});
            t = 0;
            while (!ack[vt[i].idx] && t < 50) begin @(negedge clk); t++; end
            check("ack_seen", 256'(t < 50), 256'(1));
            check("busy_run", 256'(busy), 256'(1));
            req[vt[i].idx] = 1'b0;
            t = 0;
            while (!rsp_valid[vt[i].idx] && t < 40) begin @(negedge clk); t++; end
            check("latency", 256'(t), 256'(vt[i].cyc));
            check("en_low_resp", 256'(mm_enable), 256'(0));
            @(negedge clk);
            check("busy_idle", 256'(busy), 256'(0));
        end

        // contention from reset: grants 0,1,2,3,0
        #1 reset = 1'b1;
        lat = 3;
        for (int i = 0; i < N; i++) begin
            ca[i] = W'(17 * i + 5);
            cb[i] = W'(29 + 3 * i);
            req_a[i*W +: W] = ca[i];
            req_b[i*W +: W] = cb[i];
        end
        for (int k = 0; k < 5; k++) begin
            ack_q.push_back(k % N);
            rsp_q.push_back('{k % N, mod_model(ca[k % N], cb[k % N]), 1'b0});
        end
        req = '1;
        repeat (2) @(negedge clk);
        #1 reset = 1'b0;
        nrsp = 0;
        t = 0;
        while (nrsp < 5 && t < 200) begin
            @(negedge clk);
            t++;
            if (rsp_valid != '0) nrsp++;
        end
        check("contention_done", 256'(nrsp), 256'(5));
        req = '0;
        repeat (4) @(negedge clk);
        check("contention_ack_q", 256'(ack_q.size()), 256'(0));
        check("contention_rsp_q", 256'(rsp_q.size()), 256'(0));

        // reset 3 cycles into RUN for requester 1, then requesters 0 and 3 compete
        lat = 0;
        req_a[1*W +: W] = W'(9);
        req_b[1*W +: W] = W'(8);
        ack_q.push_back(1);
        req = 4'b0010;
        t = 0;
        while (!ack[1] && t < 50) begin @(negedge clk); t++; end
        check("abort_ack_seen", 256'(t < 50), 256'(1));
        req = '0;
        repeat (3) @(negedge clk);
        #1 reset = 1'b1;
        #1 check_all_zero("midrun");
        lat = 2;
        req_a[0*W +: W] = W'(6);
        req_b[0*W +: W] = W'(7);
        req_a[3*W +: W] = W'(4);
        req_b[3*W +: W] = W'(4);
        ack_q.push_back(0);
        rsp_q.push_back('{0, mod_model(W'(6), W'(7)), 1'b0});
        req = 4'b1001;
        @(negedge clk);
        #1 reset = 1'b0;
        t = 0;
        while (!ack[0] && t < 50) begin
            @(negedge clk);
            t++;
            if (ack[3]) break;
        end
        check("post_reset_grant0", 256'(ack), 256'(4'b0001));
        req = '0;
        t = 0;
        while (rsp_valid == '0 && t < 40) begin @(negedge clk); t++; end
        check("post_reset_rsp", 256'(rsp_valid), 256'(4'b0001));
        repeat (4) @(negedge clk);
        check("final_ack_q", 256'(ack_q.size()), 256'(0));
        check("final_rsp_q", 256'(rsp_q.size()), 256'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/modmul_arbiter.md
MODMUL_ARBITER -- requirements
Module: modmul_arbiter

Interface
REQ-001 Parameter WIDTH, default 128, operand/result width; matches the shared ModMul width.
REQ-002 Parameter NREQ, default 4, number of requesters (2..8).
REQ-003 Parameter TIMEOUT, default 1024, max RUN cycles before abort.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 req  input  NREQ  per-requester request level.
REQ-007 req_a  input  NREQ*WIDTH  operand a; requester i at bits [i*WIDTH +: WIDTH].
REQ-008 req_b  input  NREQ*WIDTH  operand b; same packing.
REQ-009 ack  output  NREQ  one-cycle pulse: request accepted, operands captured.
REQ-010 rsp_valid  output  NREQ  one-cycle pulse to owning requester: result available.
REQ-011 rsp_err  output  1  high with rsp_valid when the operation timed out.
REQ-012 rsp_r  output  WIDTH  result; valid only while any rsp_valid bit is high.
REQ-013 busy  output  1  high in RUN and RESP.
REQ-014 mm_a, mm_b  output  WIDTH  operands to ModMul.
REQ-015 mm_enable  output  1  ModMul enable.
REQ-016 mm_r  input  WIDTH  ModMul result.
REQ-017 mm_done  input  1  ModMul completion.

Function
REQ-018 FSM states IDLE, RUN, RESP; exactly one active.
REQ-019 IDLE: on an edge with req != 0, select the winner, register its operands into mm_a/mm_b, record owner, assert ack[owner] for the next cycle only, go to RUN.
REQ-020 Arbitration is round-robin: search starts at (last owner + 1) mod NREQ, wrapping; after reset, last owner = NREQ-1, so requester 0 has first priority.
REQ-021 mm_enable is 1 exactly while in RUN; mm_a/mm_b stay constant throughout RUN.
REQ-022 RUN: on an edge with mm_done=1, capture mm_r into rsp_r, assert rsp_valid[owner] for one cycle, rsp_err=0, go to RESP.
REQ-023 RUN: a cycle counter starts at 0 on entry; if it reaches TIMEOUT-1 without mm_done, go to RESP with rsp_valid[owner]=1, rsp_err=1, rsp_r=0.
REQ-024 mm_done and TIMEOUT on the same edge: mm_done wins, with a normal result.
REQ-025 RESP lasts one cycle, then IDLE; mm_enable is therefore low for at least 2 cycles between operations (RESP, IDLE).
REQ-026 Latency from grant edge to rsp_valid = ModMul latency + 1 cycle; minimum req-to-next-grant spacing is 3 cycles per operation.
REQ-027 A requester holds req and operands stable until ack; req still high after ack counts as a new request.
REQ-028 req changes outside IDLE, and mm_done outside RUN, are ignored.
REQ-029 At most one ack bit and at most one rsp_valid bit are high in any cycle.
REQ-030 ack, rsp_valid, rsp_err, busy and mm_enable are registered outputs.

Reset
REQ-031 While reset is high, asynchronously:
- state = IDLE, last owner = NREQ-1
- ack = 0, rsp_valid = 0, rsp_err = 0, busy = 0, mm_enable = 0
- mm_a = 0, mm_b = 0, rsp_r = 0, counter = 0
REQ-032 Reset asserted during RUN aborts the operation with no rsp_valid; the first grant after release goes to requester 0 if requesting.

Verification
REQ-033 Single request: with ModMul p=37, WIDTH=128, requester 2 sends a=123, b=456 -> ack[2] one cycle, then rsp_valid[2] with rsp_r=33, rsp_err=0.
REQ-034 Contention: all 4 req high continuously after reset -> grant order 0,1,2,3,0; each rsp_valid matches (a*b) mod 37 for that requester's operands.
REQ-035 Timeout: stub ModMul that never asserts mm_done, TIMEOUT=16 -> rsp_valid[owner] and rsp_err=1 exactly 16 cycles after RUN entry, rsp_r=0, mm_enable low the next cycle.
REQ-036 Tie: mm_done asserted on the TIMEOUT-1 count edge -> normal result, rsp_err=0.
REQ-037 Reset mid-RUN: reset pulse 3 cycles into RUN -> all outputs 0 immediately; no rsp_valid; next grant goes to requester 0.
REQ-038 Protocol checks throughout: ack/rsp_valid one-hot-or-zero, mm_a/mm_b stable while mm_enable=1, at least 2 low cycles of mm_enable between operations.
